// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ producers, the arbiter and the FIFO's wen/wdata/full side.
// The arbiter takes the slave view; the producer/FIFO side takes the master view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wen;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [ID_WIDTH-1:0]           fifo_wid;
  logic                          locked;
  logic [ID_WIDTH-1:0]           owner_id;
  logic                          burst_trunc;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wen, fifo_wdata, fifo_wid, locked, owner_id, burst_trunc
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wen, fifo_wdata, fifo_wid, locked, owner_id, burst_trunc
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are zero-latency: the winning beat is written in the same cycle it is selected.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam bit SINGLE_BEAT = (MAX_BURST == 1);

  state_t                state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   owner_id;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  burst_trunc;

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   sel;
  logic                  sel_last;
  logic                  xfer;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Modulo-NUM_REQ increment; off is always below NUM_REQ so one subtraction wraps.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_REQ)) sum = sum - 32'(NUM_REQ);
    return sum[ID_WIDTH-1:0];
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_inc(rr_ptr, k);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gating with rst_n keeps every handshake output quiet while reset is held.
  always_comb begin
    sel   = (state == LOCKED) ? owner_id : grant_idx;
    ready = '0;
    xfer  = 1'b0;
    if (rst_n && !bus.fifo_full) begin
      if (state == LOCKED) begin
        ready[owner_id] = 1'b1;
        xfer            = bus.req_valid[owner_id];
      end else if (grant_found) begin
        ready[grant_idx] = 1'b1;
        xfer             = 1'b1;
      end
    end
    sel_last = bus.req_last[sel];
  end

  assign bus.req_ready   = ready;
  assign bus.fifo_wen    = xfer;
  assign bus.fifo_wdata  = xfer ? data_arr[sel] : '0;
  assign bus.fifo_wid    = xfer ? sel : '0;
  assign bus.locked      = (state == LOCKED);
  assign bus.owner_id    = owner_id;
  assign bus.burst_trunc = burst_trunc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      owner_id    <= '0;
      burst_trunc <= 1'b0;
    end else begin
      burst_trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            owner_id <= grant_idx;
            if (sel_last || SINGLE_BEAT) begin
              rr_ptr      <= wrap_inc(grant_idx, 1);
              burst_trunc <= !sel_last;
            end else begin
              state    <= LOCKED;
              beat_cnt <= CNT_WIDTH'(1);
            end
          end
        end
        LOCKED: begin
          if (xfer) begin
            if (sel_last || beat_cnt == CNT_WIDTH'(MAX_BURST - 1)) begin
              state       <= IDLE;
              rr_ptr      <= wrap_inc(owner_id, 1);
              beat_cnt    <= '0;
              burst_trunc <= !sel_last;
            end else begin
              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: a 4-requester and a 3-requester instance,
// with expected {wid,data} words queued as stimulus is driven and popped on each write.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus4 ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) bus3 ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp4_q [$];
  logic [9:0] exp3_q [$];

  // Write monitors: every FIFO write must match the next queued expectation.
  always @(negedge clk) begin : mon4
    logic [9:0] got, exp_w;
    if (rst_n === 1'b1 && bus4.fifo_wen === 1'b1) begin
      got = {bus4.fifo_wid, bus4.fifo_wdata};
      n_checks++;
      if (exp4_q.size() == 0) begin
        $display("FAIL wr4_unexpected: got wid/data=%h, required no write", got);
      end else begin
        exp_w = exp4_q.pop_front();
        if (got !== exp_w) $display("FAIL wr4_word: got wid/data=%h, required %h", got, exp_w);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin : mon3
    logic [9:0] got, exp_w;
    if (rst_n === 1'b1 && bus3.fifo_wen === 1'b1) begin
      got = {bus3.fifo_wid, bus3.fifo_wdata};
      n_checks++;
      if (exp3_q.size() == 0) begin
        $display("FAIL wr3_unexpected: got wid/data=%h, required no write", got);
      end else begin
        exp_w = exp3_q.pop_front();
        if (got !== exp_w) $display("FAIL wr3_word: got wid/data=%h, required %h", got, exp_w);
        else n_pass++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.req_valid = 4'b1111;
    bus4.req_last  = 4'b1111;
    bus4.req_data  = 32'h44332211;
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus4.fifo_wen !== 1'b0) $display("FAIL rst_wen: got %b, required 0", bus4.fifo_wen); else n_pass++;
    n_checks++; if (bus4.req_ready !== 4'b0000) $display("FAIL rst_ready: got %b, required 0000", bus4.req_ready); else n_pass++;
    n_checks++; if (bus4.fifo_wdata !== 8'h00 || bus4.fifo_wid !== 2'd0)
      $display("FAIL rst_wdata_wid: got %h/%0d, required 00/0", bus4.fifo_wdata, bus4.fifo_wid); else n_pass++;
    n_checks++; if (bus4.locked !== 1'b0 || bus4.burst_trunc !== 1'b0 || bus4.owner_id !== 2'd0)
      $display("FAIL rst_state: got locked=%b trunc=%b owner=%0d, required 0/0/0", bus4.locked, bus4.burst_trunc, bus4.owner_id); else n_pass++;
    next_cycle();
    bus4.req_valid = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus4.fifo_wen !== 1'b0) $display("FAIL idle_no_req_wen: got %b, required 0", bus4.fifo_wen); else n_pass++;
    next_cycle();
  endtask

  task automatic test_round_robin();
    bus4.req_last  = 4'b1111;
    bus4.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp4_q.push_back({2'(i), 8'(8'h10 + i)});
      @(negedge clk);
      n_checks++; if (bus4.req_ready !== 4'(1 << i))
        $display("FAIL rr_ready[%0d]: got %b, required %b", i, bus4.req_ready, 4'(1 << i)); else n_pass++;
      next_cycle();
    end
    bus4.req_valid = 4'b0000;
  endtask

  task automatic test_packet_lock();
    bus4.req_last  = 4'b0100;
    bus4.req_valid = 4'b0110;
    bus4.req_data  = {8'h00, 8'hB0, 8'hA0, 8'h00};
    exp4_q.push_back({2'd1, 8'hA0});
    @(negedge clk);
    n_checks++; if (bus4.req_ready !== 4'b0010) $display("FAIL lock_grant: got %b, required 0010", bus4.req_ready); else n_pass++;
    next_cycle();
    for (int b = 1; b < 3; b++) begin
      bus4.req_data = {8'h00, 8'hB0, 8'(8'hA0 + b), 8'h00};
      if (b == 2) bus4.req_last = 4'b0110;
      exp4_q.push_back({2'd1, 8'(8'hA0 + b)});
      @(negedge clk);
      n_checks++; if (bus4.locked !== 1'b1 || bus4.owner_id !== 2'd1)
        $display("FAIL lock_held[%0d]: got locked=%b owner=%0d, required 1/1", b, bus4.locked, bus4.owner_id); else n_pass++;
      n_checks++; if (bus4.req_ready !== 4'b0010)
        $display("FAIL lock_ready[%0d]: got %b, required 0010", b, bus4.req_ready); else n_pass++;
      next_cycle();
    end
    bus4.req_valid = 4'b0100;
    exp4_q.push_back({2'd2, 8'hB0});
    @(negedge clk);
    n_checks++; if (bus4.locked !== 1'b0 || bus4.req_ready !== 4'b0100)
      $display("FAIL lock_release: got locked=%b ready=%b, required 0/0100", bus4.locked, bus4.req_ready); else n_pass++;
    next_cycle();
    bus4.req_valid = 4'b0000;
  endtask

  task automatic test_burst_trunc();
    bus4.req_last = 4'b1000;
    for (int b = 0; b < 8; b++) begin
      bus4.req_valid = (b == 0) ? 4'b0001 : 4'b1001;
      bus4.req_data  = {8'hD0, 16'h0000, 8'(8'hC0 + b)};
      exp4_q.push_back({2'd0, 8'(8'hC0 + b)});
      @(negedge clk);
      n_checks++; if (bus4.req_ready !== 4'b0001 || bus4.burst_trunc !== 1'b0)
        $display("FAIL burst_beat[%0d]: got ready=%b trunc=%b, required 0001/0", b, bus4.req_ready, bus4.burst_trunc); else n_pass++;
      next_cycle();
    end
    bus4.req_data = {8'hD0, 16'h0000, 8'hC8};
    exp4_q.push_back({2'd3, 8'hD0});
    @(negedge clk);
    n_checks++; if (bus4.burst_trunc !== 1'b1) $display("FAIL burst_pulse: got %b, required 1", bus4.burst_trunc); else n_pass++;
    n_checks++; if (bus4.locked !== 1'b0 || bus4.req_ready !== 4'b1000)
      $display("FAIL burst_handover: got locked=%b ready=%b, required 0/1000", bus4.locked, bus4.req_ready); else n_pass++;
    next_cycle();
    bus4.req_valid = 4'b0001;
    bus4.req_last  = 4'b0000;
    exp4_q.push_back({2'd0, 8'hC8});
    @(negedge clk);
    n_checks++; if (bus4.burst_trunc !== 1'b0) $display("FAIL burst_pulse_width: got %b, required 0", bus4.burst_trunc); else n_pass++;
    next_cycle();
    bus4.req_data = {8'hD0, 16'h0000, 8'hC9};
    bus4.req_last = 4'b0001;
    exp4_q.push_back({2'd0, 8'hC9});
    @(negedge clk);
    n_checks++; if (bus4.locked !== 1'b1) $display("FAIL burst_tail_lock: got %b, required 1", bus4.locked); else n_pass++;
    next_cycle();
    bus4.req_valid = 4'b0000;
    bus4.req_last  = 4'b0000;
  endtask

  task automatic test_full_stall();
    bus4.req_valid = 4'b0110;
    bus4.req_last  = 4'b0100;
    bus4.req_data  = {8'h00, 8'hB1, 8'hE0, 8'h00};
    bus4.fifo_full = 1'b1;
    @(negedge clk);
    n_checks++; if (bus4.fifo_wen !== 1'b0 || bus4.req_ready !== 4'b0000)
      $display("FAIL idle_full: got wen=%b ready=%b, required 0/0000", bus4.fifo_wen, bus4.req_ready); else n_pass++;
    next_cycle();
    bus4.fifo_full = 1'b0;
    exp4_q.push_back({2'd1, 8'hE0});
    next_cycle();
    bus4.req_data  = {8'h00, 8'hB1, 8'hE1, 8'h00};
    bus4.fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_checks++; if (bus4.fifo_wen !== 1'b0 || bus4.req_ready !== 4'b0000)
        $display("FAIL stall_quiet[%0d]: got wen=%b ready=%b, required 0/0000", s, bus4.fifo_wen, bus4.req_ready); else n_pass++;
      n_checks++; if (bus4.locked !== 1'b1 || bus4.owner_id !== 2'd1)
        $display("FAIL stall_hold[%0d]: got locked=%b owner=%0d, required 1/1", s, bus4.locked, bus4.owner_id); else n_pass++;
      next_cycle();
    end
    bus4.fifo_full = 1'b0;
    for (int b = 1; b < 7; b++) begin
      bus4.req_data = {8'h00, 8'hB1, 8'(8'hE0 + b), 8'h00};
      if (b == 6) bus4.req_last = 4'b0110;
      exp4_q.push_back({2'd1, 8'(8'hE0 + b)});
      @(negedge clk);
      n_checks++; if (bus4.burst_trunc !== 1'b0 || bus4.req_ready !== 4'b0010)
        $display("FAIL stall_resume[%0d]: got trunc=%b ready=%b, required 0/0010", b, bus4.burst_trunc, bus4.req_ready); else n_pass++;
      next_cycle();
    end
    bus4.req_valid = 4'b0100;
    exp4_q.push_back({2'd2, 8'hB1});
    next_cycle();
    bus4.req_valid = 4'b0000;
    bus4.req_last  = 4'b0000;
  endtask

  task automatic test_rr_three();
    logic [2:0] vt [5];
    int         gt [5];
    vt = '{3'b010, 3'b011, 3'b011, 3'b111, 3'b101};
    gt = '{1, 0, 1, 2, 0};
    bus3.req_last = 3'b111;
    bus3.req_data = {8'h32, 8'h31, 8'h30};
    for (int c = 0; c < 5; c++) begin
      bus3.req_valid = vt[c];
      exp3_q.push_back({2'(gt[c]), 8'(8'h30 + gt[c])});
      @(negedge clk);
      n_checks++; if (bus3.req_ready !== 3'(1 << gt[c]))
        $display("FAIL rr3_ready[%0d]: got %b, required %b", c, bus3.req_ready, 3'(1 << gt[c])); else n_pass++;
      next_cycle();
    end
    bus3.req_valid = 3'b000;
  endtask

  task automatic test_reset_mid_packet();
    bus4.req_last  = 4'b0000;
    bus4.req_valid = 4'b1000;
    bus4.req_data  = {8'hF0, 24'h000000};
    exp4_q.push_back({2'd3, 8'hF0});
    next_cycle();
    bus4.req_data = {8'hF1, 24'h000000};
    exp4_q.push_back({2'd3, 8'hF1});
    @(negedge clk);
    n_checks++; if (bus4.locked !== 1'b1) $display("FAIL mid_locked: got %b, required 1", bus4.locked); else n_pass++;
    next_cycle();
    bus4.req_valid = 4'b1011;
    bus4.req_data  = {8'hF2, 8'h00, 8'h51, 8'h50};
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus4.locked !== 1'b0 || bus4.owner_id !== 2'd0)
      $display("FAIL async_rst_state: got locked=%b owner=%0d, required 0/0", bus4.locked, bus4.owner_id); else n_pass++;
    n_checks++; if (bus4.fifo_wen !== 1'b0 || bus4.req_ready !== 4'b0000 || bus4.fifo_wdata !== 8'h00)
      $display("FAIL async_rst_out: got wen=%b ready=%b wdata=%h, required 0/0000/00", bus4.fifo_wen, bus4.req_ready, bus4.fifo_wdata); else n_pass++;
    next_cycle();
    bus4.req_valid = 4'b1010;
    bus4.req_last  = 4'b0010;
    rst_n = 1'b1;
    exp4_q.push_back({2'd1, 8'h51});
    @(negedge clk);
    n_checks++; if (bus4.req_ready !== 4'b0010)
      $display("FAIL post_rst_grant: got %b, required 0010", bus4.req_ready); else n_pass++;
    next_cycle();
    bus4.req_valid = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    bus4.req_valid = '0; bus4.req_last = '0; bus4.req_data = '0; bus4.fifo_full = 1'b0;
    bus3.req_valid = '0; bus3.req_last = '0; bus3.req_data = '0; bus3.fifo_full = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_burst_trunc();
    test_full_stall();
    test_rr_three();
    test_reset_mid_packet();
    next_cycle();
    next_cycle();
    n_checks++; if (exp4_q.size() != 0) $display("FAIL wr4_missing: got %0d unwritten beats, required 0", exp4_q.size()); else n_pass++;
    n_checks++; if (exp3_q.size() != 0) $display("FAIL wr3_missing: got %0d unwritten beats, required 0", exp3_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
